lfsr_checker: RTL and testbench

Serial PRBS checker that self-synchronises to the bit stream of a Fibonacci LFSR and tracks pattern errors. The generator shifts left and inserts its feedback bit at the LSB; the checker consumes that LSB stream one bit per valid beat. It then predicts every following bit, declares lock, counts mismatches and drops lock when the stream is lost. It is the receive-side companion to the LFSR pattern generator in link and datapath self-test.

---
 rtl/lfsr_pkg.sv | 30 +++
 rtl/lfsr_chk_sat_cnt.sv | 23 ++
 rtl/lfsr_checker.sv | 132 +++++++++++++
 tb/tb_lfsr_checker.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the PRBS checker.
// Optional build macro: LFSR_CHK_ZERO_REJECT_EN.
package lfsr_pkg;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2,
        LOST   = 2'd3
    } state_t;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_TAP      = 1;
    localparam int DEF_LOCK_CNT = 8;
    localparam int DEF_LOSS_CNT = 3;
    localparam int DEF_ERR_W    = 16;

    localparam int FB_MAX_W = 64;
    localparam int FB_IDX_W = $clog2(FB_MAX_W);

    // Caller zero-extends its register into the fixed-width argument.
    function automatic logic fb(
        input logic [FB_MAX_W-1:0] s,
        input int                  tap,
        input int                  width = DEF_WIDTH
    );
        return s[FB_IDX_W'(width - 1)] ^ s[FB_IDX_W'(tap)];
    endfunction

endpackage

// File: rtl/lfsr_chk_sat_cnt.sv
// Saturating up-counter; clear takes priority but a
// coincident increment still counts once.
module lfsr_chk_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? W'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising Fibonacci-LFSR stream checker.
// Build macro LFSR_CHK_ZERO_REJECT_EN refuses the all-zero lock.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int TAP      = DEF_TAP,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int LOSS_CNT = DEF_LOSS_CNT,
    parameter int ERR_W    = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_i,
    input  logic             bit_i,
    input  logic             err_clr_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic [1:0]       state_o
);

    localparam int SEED_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);

    state_t             state;
    logic [WIDTH-1:0]   s;
    logic [SEED_W-1:0]  seed_cnt;
    logic [MATCH_W-1:0] match_cnt;
    logic [MISS_W-1:0]  miss_cnt;

    logic             p;
    logic             miss;
    logic             err_inc;
    logic [WIDTH-1:0] s_in;

    assign p       = fb(FB_MAX_W'(s), TAP, WIDTH);
    assign s_in    = {s[WIDTH-2:0], bit_i};
    assign miss    = bit_i != p;
    assign err_inc = valid_i && (state == LOCKED) && miss;
    assign state_o = state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= SEED;
            s         <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked_o  <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            err_o <= 1'b0;
            unique case (state)
                SEED: begin
                    if (valid_i) begin
                        s <= s_in;
                        if (seed_cnt == SEED_W'(WIDTH - 1)) begin
                            seed_cnt <= '0;
`ifdef LFSR_CHK_ZERO_REJECT_EN
                            if (s_in != '0) begin
                                state     <= VERIFY;
                                match_cnt <= '0;
                            end
`else
                            state     <= VERIFY;
                            match_cnt <= '0;
`endif
                        end else begin
                            seed_cnt <= seed_cnt + 1'b1;
                        end
                    end
                end
                VERIFY: begin
                    if (valid_i) begin
                        s <= s_in;
                        if (miss) begin
                            state    <= SEED;
                            seed_cnt <= '0;
`ifdef LFSR_CHK_ZERO_REJECT_EN
                        end else if (s_in == '0) begin
                            state    <= SEED;
                            seed_cnt <= '0;
`endif
                        end else if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                            state    <= LOCKED;
                            locked_o <= 1'b1;
                            miss_cnt <= '0;
                        end else begin
                            match_cnt <= match_cnt + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (valid_i) begin
                        // Free-run on the prediction so bit errors stay local.
                        s <= {s[WIDTH-2:0], p};
                        if (miss) begin
                            err_o <= 1'b1;
                            if (miss_cnt == MISS_W'(LOSS_CNT - 1)) begin
                                state    <= LOST;
                                locked_o <= 1'b0;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 1'b1;
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                end
                LOST: begin
                    state    <= SEED;
                    seed_cnt <= '0;
                end
                default: state <= SEED;
            endcase
        end
    end

    lfsr_chk_sat_cnt #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (err_inc),
        .clr     (err_clr_i),
        .cnt     (err_cnt_o)
    );

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker with default parameters.
// Honours LFSR_CHK_ZERO_REJECT_EN for the all-zero expectations.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_i;
    logic        bit_i;
    logic        err_clr_i;
    logic        locked_o;
    logic        err_o;
    logic [15:0] err_cnt_o;
    logic [1:0]  state_o;

    typedef struct {
        int st;
        int lk;
        int er;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   cyc    = 0;
    int   ph     = 0;

    // Generator seeded 4'b0001 emits 0,1,0,0,0,1 (bit k at index k).
    logic [5:0] pat = 6'b100010;

    lfsr_checker dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid_i   (valid_i),
        .bit_i     (bit_i),
        .err_clr_i (err_clr_i),
        .locked_o  (locked_o),
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        n_tot++;
        if (got == want) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
    endtask

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("state_o", int'(state_o), e.st);
            chk("locked_o", int'(locked_o), e.lk);
            chk("err_o", int'(err_o), e.er);
            chk("err_cnt_o", int'(err_cnt_o), e.cnt);
        end
    end

    task automatic step(input int rn, input int v, input int b, input int c,
                        input int st, input int lk, input int er, input int cnt);
        exp_t e;
        @(negedge clk);
        reset_n   = (rn != 0);
        valid_i   = (v != 0);
        bit_i     = (b != 0);
        err_clr_i = (c != 0);
        e.st = st; e.lk = lk; e.er = er; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic beat(input int v, input int inv, input int c,
                        input int st, input int lk, input int er, input int cnt);
        int b;
        b = int'(pat[ph[2:0]]) ^ inv;
        step(1, v, b, c, st, lk, er, cnt);
        if (v != 0) ph = (ph + 1) % 6;
    endtask

    function automatic int lock_st(input int i);
        return (i < 3) ? 0 : ((i < 11) ? 1 : 2);
    endfunction

    task automatic lock_seq(input int cnt);
        for (int i = 0; i < 12; i++)
            beat(1, 0, 0, lock_st(i), (i == 11) ? 1 : 0, 0, cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1);
    end

    initial begin
        int pst;
        int plk;
        reset_n = 1'b0; valid_i = 1'b0; bit_i = 1'b0; err_clr_i = 1'b0;

        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0);

        // Clean lock, then stays locked with no errors.
        lock_seq(0);
        repeat (6) beat(1, 0, 0, 2, 1, 0, 0);

        // Single flipped bit.
        beat(1, 1, 0, 2, 1, 1, 1);
        repeat (6) beat(1, 0, 0, 2, 1, 0, 1);

        // Clear while idle, then three misses drop lock.
        beat(0, 0, 1, 2, 1, 0, 0);
        beat(1, 1, 0, 2, 1, 1, 1);
        beat(1, 1, 0, 2, 1, 1, 2);
        beat(1, 1, 0, 3, 0, 1, 3);
        step(1, 1, 1, 0, 0, 0, 0, 3);
        lock_seq(3);

        // Clear coinciding with a miss, and non-consecutive misses.
        beat(1, 1, 1, 2, 1, 1, 1);
        beat(1, 0, 0, 2, 1, 0, 1);
        beat(1, 1, 0, 2, 1, 1, 2);
        beat(1, 1, 0, 2, 1, 1, 3);
        beat(1, 0, 0, 2, 1, 0, 3);
        beat(1, 1, 0, 2, 1, 1, 4);
        beat(1, 0, 0, 2, 1, 0, 4);

        // Reset mid-lock with valid high.
        step(0, 1, 1, 0, 0, 0, 0, 0);

        // Mismatch at beat 8 during VERIFY.
        for (int i = 0; i < 7; i++) beat(1, 0, 0, lock_st(i), 0, 0, 0);
        beat(1, 1, 0, 0, 0, 0, 0);
        lock_seq(0);

        // 50% valid.
        step(0, 0, 0, 0, 0, 0, 0, 0);
        pst = 0; plk = 0;
        for (int i = 0; i < 12; i++) begin
            beat(0, 0, 0, pst, plk, 0, 0);
            pst = lock_st(i);
            plk = (i == 11) ? 1 : 0;
            beat(1, 0, 0, pst, plk, 0, 0);
        end
        beat(0, 0, 0, 2, 1, 0, 0);

        // All-zero stream.
        step(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
`ifdef LFSR_CHK_ZERO_REJECT_EN
            step(1, 1, 0, 0, 0, 0, 0, 0);
`else
            step(1, 1, 0, 0, lock_st(i), (i == 11) ? 1 : 0, 0, 0);
`endif
        end

        repeat (3) @(negedge clk);
        n_tot++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain got=%0d want=0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
